// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and key-event payload for the PS/2 scancode receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_G = 8'h34;
    localparam logic [7:0] KEY_R = 8'h2D;
    localparam logic [7:0] KEY_F = 8'h2B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser, glitch filter and falling-edge detector for the raw PS/2 clock line.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic line_raw,
    output logic fall
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             meta;
    logic             line_sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            level     <= 1'b1;
            cnt       <= '0;
            fall      <= 1'b0;
        end else begin
            meta      <= line_raw;
            line_sync <= meta;
            fall      <= 1'b0;
            if (line_sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                level <= line_sync;
                cnt   <= '0;
                fall  <= ~line_sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard frame receiver with E0/F0 prefix decoding and one-cycle make/break strobes.
// Optional build macro: TYPEMATIC_FILTER_EN suppresses keyboard auto-repeat makes.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TO_W           = 17
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_out,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    logic clk_fall;
    logic dat_meta;
    logic dat_sync;

    ps2_state_t      state, state_d;
    logic [2:0]      bitcnt, bitcnt_d;
    logic [7:0]      shreg, shreg_d;
    logic            par_bit, par_d;
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic            ext_flag, ext_d;
    logic            brk_flag, brk_d;
    logic [7:0]      ps2_out_d;
    logic            key_valid_d;
    key_evt_t        key_q, key_d;
    logic            frame_err_d;
    logic            stop_good_c;
    logic            repeat_c;

`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] last_make, last_make_d;
    logic       held, held_d;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock    (clock),
        .resetn   (resetn),
        .line_raw (ps2_clk),
        .fall     (clk_fall)
    );

    // Data line needs only synchronising; it is sampled well after it settles.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            ps2_out   <= '0;
            key_valid <= 1'b0;
            key_q     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            bitcnt    <= bitcnt_d;
            shreg     <= shreg_d;
            par_bit   <= par_d;
            to_cnt    <= to_cnt_d;
            ext_flag  <= ext_d;
            brk_flag  <= brk_d;
            ps2_out   <= ps2_out_d;
            key_valid <= key_valid_d;
            key_q     <= key_d;
            frame_err <= frame_err_d;
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    always_ff @(posedge clock) begin
        if (!resetn) begin
            last_make <= '0;
            held      <= 1'b0;
        end else begin
            last_make <= last_make_d;
            held      <= held_d;
        end
    end
`endif

    assign key_code     = key_q.code;
    assign key_release  = key_q.brk;
    assign key_extended = key_q.ext;

    assign stop_good_c = (state == ST_STOP) && clk_fall && dat_sync
                         && odd_parity_ok(shreg, par_bit);

`ifdef TYPEMATIC_FILTER_EN
    assign repeat_c = held && !brk_flag && (shreg == last_make);
`else
    assign repeat_c = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        bitcnt_d    = bitcnt;
        shreg_d     = shreg;
        par_d       = par_bit;
        to_cnt_d    = to_cnt;
        ext_d       = ext_flag;
        brk_d       = brk_flag;
        ps2_out_d   = '0;
        key_valid_d = 1'b0;
        key_d       = '0;
        frame_err_d = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
        last_make_d = last_make;
        held_d      = held;
`endif

        case (state)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (clk_fall) begin
                    if (!dat_sync) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (clk_fall) begin
                    shreg_d  = {dat_sync, shreg[7:1]};
                    bitcnt_d = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    par_d   = dat_sync;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    state_d = ST_IDLE;
                    if (!stop_good_c) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Mid-frame watchdog: a stalled keyboard aborts the frame and forgets any prefix.
        if (state != ST_IDLE) begin
            if (clk_fall) begin
                to_cnt_d = '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = ST_IDLE;
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
            end else begin
                to_cnt_d = to_cnt + TO_W'(1);
            end
        end

        if (stop_good_c) begin
            if (shreg == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (shreg == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!repeat_c) begin
                    key_valid_d = 1'b1;
                    key_d.code  = shreg;
                    key_d.brk   = brk_flag;
                    key_d.ext   = ext_flag;
                    if (!brk_flag && (shreg != 8'h00)) begin
                        ps2_out_d = shreg;
                    end
                end
`ifdef TYPEMATIC_FILTER_EN
                if (!brk_flag) begin
                    last_make_d = shreg;
                    held_d      = 1'b1;
                end else if (shreg == last_make) begin
                    held_d = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed self-checking bench for ps2_scancode_rx (default build, typematic filter off).
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int unsigned HALF = 20;
    localparam int unsigned TOUT = 400;

    logic       clock = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ps2_out;
    logic       key_valid;
    logic       key_release;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    int checks = 0;
    int passed = 0;

    int         out_cycles = 0;
    int         valid_cnt  = 0;
    int         err_cnt    = 0;
    logic [7:0] last_out   = 8'h00;
    logic [7:0] last_code  = 8'h00;
    logic       last_rel   = 1'b0;
    logic       last_ext   = 1'b0;

    int s_out, s_valid, s_err;

    always #5 clock = ~clock;

    ps2_scancode_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TOUT),
        .TO_W           (17)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .ps2_out      (ps2_out),
        .key_valid    (key_valid),
        .key_release  (key_release),
        .key_extended (key_extended),
        .key_code     (key_code),
        .frame_err    (frame_err)
    );

    // Record every output pulse so steps can compare per-scenario deltas.
    always @(negedge clock) begin
        if (ps2_out != 8'h00) begin
            out_cycles <= out_cycles + 1;
            last_out   <= ps2_out;
        end
        if (key_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_code <= key_code;
            last_rel  <= key_release;
            last_ext  <= key_extended;
        end
        if (frame_err) begin
            err_cnt <= err_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic snap();
        wait_cyc(1);
        s_out   = out_cycles;
        s_valid = valid_cnt;
        s_err   = err_cnt;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic stop);
        logic [7:0] c;
        c = code;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(c[i]);
        send_bit((~^c) ^ flip_par);
        send_bit(stop);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
    endtask

    initial begin
        resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(4);
        resetn = 1'b1;
        wait_cyc(2);
        check("rst_ps2_out", 32'(ps2_out), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);

        // Plain make 0x34
        snap();
        send_frame(KEY_G, 1'b0, 1'b1);
        wait_cyc(2);
        check("g_out_pulses", 32'(out_cycles - s_out), 32'd1);
        check("g_out_val", 32'(last_out), 32'h34);
        check("g_valid_pulses", 32'(valid_cnt - s_valid), 32'd1);
        check("g_code", 32'(last_code), 32'h34);
        check("g_rel", 32'(last_rel), 32'h0);
        check("g_ext", 32'(last_ext), 32'h0);
        check("g_err", 32'(err_cnt - s_err), 32'd0);
        check("g_out_idle", 32'(ps2_out), 32'h0);

        // Break F0 0x23, then make 0x2D
        snap();
        send_frame(PS2_PREFIX_BRK, 1'b0, 1'b1);
        send_frame(KEY_D, 1'b0, 1'b1);
        wait_cyc(2);
        check("brk_out_pulses", 32'(out_cycles - s_out), 32'd0);
        check("brk_valid_pulses", 32'(valid_cnt - s_valid), 32'd1);
        check("brk_code", 32'(last_code), 32'h23);
        check("brk_rel", 32'(last_rel), 32'h1);
        snap();
        send_frame(KEY_R, 1'b0, 1'b1);
        wait_cyc(2);
        check("r_out_pulses", 32'(out_cycles - s_out), 32'd1);
        check("r_out_val", 32'(last_out), 32'h2D);
        check("r_rel", 32'(last_rel), 32'h0);

        // Extended E0 0x75, then plain 0x2B
        snap();
        send_frame(PS2_PREFIX_EXT, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        wait_cyc(2);
        check("ext_code", 32'(last_code), 32'h75);
        check("ext_flag", 32'(last_ext), 32'h1);
        check("ext_out_val", 32'(last_out), 32'h75);
        check("ext_valid_pulses", 32'(valid_cnt - s_valid), 32'd1);
        send_frame(KEY_F, 1'b0, 1'b1);
        wait_cyc(2);
        check("f_ext_cleared", 32'(last_ext), 32'h0);
        check("f_out_val", 32'(last_out), 32'h2B);

        // Parity error
        snap();
        send_frame(KEY_G, 1'b1, 1'b1);
        wait_cyc(2);
        check("par_err_pulses", 32'(err_cnt - s_err), 32'd1);
        check("par_out_pulses", 32'(out_cycles - s_out), 32'd0);
        check("par_valid_pulses", 32'(valid_cnt - s_valid), 32'd0);

        // 5-cycle clock glitch must not start a frame
        snap();
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(40);
        check("glitch_err", 32'(err_cnt - s_err), 32'd0);
        send_frame(KEY_D, 1'b0, 1'b1);
        wait_cyc(2);
        check("glitch_next_code", 32'(last_code), 32'h23);
        check("glitch_next_valid", 32'(valid_cnt - s_valid), 32'd1);

        // Bad stop bit, then bad start bit
        snap();
        send_frame(KEY_R, 1'b0, 1'b0);
        wait_cyc(2);
        check("stop_err", 32'(err_cnt - s_err), 32'd1);
        check("stop_valid", 32'(valid_cnt - s_valid), 32'd0);
        snap();
        send_bit(1'b1);
        wait_cyc(HALF);
        check("start_err", 32'(err_cnt - s_err), 32'd1);

        // Break prefix survives a corrupted retransmitted frame
        snap();
        send_frame(PS2_PREFIX_BRK, 1'b0, 1'b1);
        send_frame(KEY_D, 1'b1, 1'b1);
        send_frame(KEY_D, 1'b0, 1'b1);
        wait_cyc(2);
        check("keep_err", 32'(err_cnt - s_err), 32'd1);
        check("keep_valid", 32'(valid_cnt - s_valid), 32'd1);
        check("keep_rel", 32'(last_rel), 32'h1);
        check("keep_out_pulses", 32'(out_cycles - s_out), 32'd0);

        // Timeout after a partial frame clears the break prefix
        send_frame(PS2_PREFIX_BRK, 1'b0, 1'b1);
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_cyc(200);
        check("to_not_yet", 32'(err_cnt - s_err), 32'd0);
        wait_cyc(TOUT + 100);
        check("to_err", 32'(err_cnt - s_err), 32'd1);
        snap();
        send_frame(KEY_D, 1'b0, 1'b1);
        wait_cyc(2);
        check("to_next_rel", 32'(last_rel), 32'h0);
        check("to_next_out", 32'(last_out), 32'h23);
        check("to_next_err", 32'(err_cnt - s_err), 32'd0);

        // Code 0x00: key_valid only, never on ps2_out
        snap();
        send_frame(8'h00, 1'b0, 1'b1);
        wait_cyc(2);
        check("zero_valid", 32'(valid_cnt - s_valid), 32'd1);
        check("zero_code", 32'(last_code), 32'h00);
        check("zero_out_pulses", 32'(out_cycles - s_out), 32'd0);

        // Reset mid-frame drops partial frame and prefix
        send_frame(PS2_PREFIX_BRK, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        resetn = 1'b0;
        wait_cyc(1);
        resetn = 1'b1;
        wait_cyc(1);
        check("mrst_out", 32'(ps2_out), 32'h0);
        check("mrst_valid", 32'(key_valid), 32'h0);
        check("mrst_err", 32'(frame_err), 32'h0);
        snap();
        send_frame(KEY_D, 1'b0, 1'b1);
        wait_cyc(2);
        check("mrst_next_out", 32'(last_out), 32'h23);
        check("mrst_next_rel", 32'(last_rel), 32'h0);
        check("mrst_next_err", 32'(err_cnt - s_err), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Upstream stage of the keyboard/field-shift block.
- Receives raw PS/2 keyboard clock and data lines, deserialises 11-bit frames, checks odd parity and decodes E0/F0 prefixes.
- Emits a one-cycle, non-zero 8-bit make code on ps2_out; the downstream stage stretches and consumes it (0x34/0x23/0x2D/0x2B).
- Also reports release and extended flags plus frame errors.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised ps2_clk samples required to accept a level change.
- TIMEOUT_CYCLES, 100000: clock cycles without a filtered falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).
- TO_W, 17: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  synchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock line, asynchronous
- ps2_dat  in  1  raw PS/2 data line, asynchronous
- ps2_out  out  8  make code; non-zero for exactly one cycle per accepted make, otherwise 0
- key_valid  out  1  one-cycle strobe, coincident with any decoded make or break
- key_release  out  1  qualifies key_valid: 1 = break (F0-prefixed)
- key_extended  out  1  qualifies key_valid: 1 = E0-prefixed
- key_code  out  8  code qualified by key_valid (make or break)
- frame_err  out  1  one-cycle strobe on parity error, bad start/stop bit, or timeout

Behaviour:
- Reset: one clock, synchronous, active-low; resetn=0 on a rising edge of clock forces every register to its reset value. Reset mid-frame discards the partial frame and the prefix flags.
- Reset values: ps2_out=0, key_code=0, key_valid=0, key_release=0, key_extended=0, frame_err=0; FSM=IDLE; counters=0; sync and filter flops=1 (idle bus).
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
  - ps2_clk then goes through the FILTER_LEN filter; the filtered level changes only after FILTER_LEN identical samples.
  - A "fall" event is filtered 1 to 0. Data is sampled (synchronised ps2_dat) on the fall cycle.
- FSM: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall, if sampled bit=0 (start) go to DATA with bitcnt=0; if bit=1, pulse frame_err and stay in IDLE.
  - DATA: on fall, shift the bit in LSB-first; after the 8th bit go to PARITY.
  - PARITY: on fall, latch the bit and go to STOP.
  - STOP: on fall, if stop=1 and (^data ^ parity)==1 the frame is good; otherwise pulse frame_err. Return to IDLE in either case.
- Timeout: in any state except IDLE the timeout counter increments each cycle and clears on fall. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear the E0/F0 flags.
- Good frame decode, evaluated in the cycle after the stop-bit fall:
  - 0xE0: set ext_flag; no output.
  - 0xF0: set brk_flag; no output.
  - Any other code: key_valid=1, key_code=code, key_release=brk_flag, key_extended=ext_flag. If brk_flag=0, also ps2_out=code. Then clear both flags.
- Latency: outputs are registered and asserted exactly 1 clock after the cycle in which the stop-bit fall is detected. They are held for 1 cycle, then return to 0.
- Bad frame: no key_valid; prefix flags are preserved. The device retransmits, so the prefix stays meaningful.
- Code 0x00 is never placed on ps2_out. A good frame with 0x00 gives key_valid only; the downstream block treats 0 as "no key".
- Back-to-back frames: a fall arriving in the output cycle is processed normally, with no lost bit.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined:
  - Keep a last_make register and a held flag.
  - A make equal to last_make while held=1 (keyboard auto-repeat) produces no ps2_out pulse and no key_valid.
  - A break of that code clears held. A different make replaces last_make and sets held.
  - Reset clears held, last_make=0.
- Undefined: every make, including auto-repeats, is reported.

Decomposition:
- Shared package ps2_pkg:
  - Constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0.
  - Game key constants KEY_W=8'h1D, KEY_A=8'h1C, KEY_S=8'h1B, KEY_D=8'h23, KEY_G=8'h34, KEY_R=8'h2D, KEY_F=8'h2B.
  - FSM state typedef.
- One natural sub-module: ps2_line_filter, holding the synchroniser, glitch filter and fall detector. It is instantiated for ps2_clk; ps2_dat uses the synchroniser only.

Test Plan:
- Frame for 0x34 (start 0, data LSB-first, parity 0, stop 1) at a 60 us bit period -> ps2_out=0x34 for 1 cycle, key_valid=1, key_release=0, key_extended=0, frame_err never set.
- F0 frame (parity 1) then 0x23 frame -> ps2_out stays 0; key_valid=1, key_code=0x23, key_release=1. A following 0x2D frame (parity 1) -> ps2_out=0x2D, key_release=0.
- E0 then 0x75 frame -> key_extended=1, key_code=0x75, ps2_out=0x75. Next plain 0x2B -> key_extended=0.
- 0x34 sent with parity bit 1 -> frame_err 1-cycle pulse, ps2_out stays 0. 5 clock-cycle glitch on ps2_clk -> no bit accepted.
- 4 bits of a frame then bus idle -> frame_err after TIMEOUT_CYCLES, FSM in IDLE; a subsequent clean 0x23 decodes correctly.
- With TYPEMATIC_FILTER_EN: 0x34 three times -> one ps2_out pulse; F0,0x34 then 0x34 -> second pulse. resetn=0 mid-frame -> all outputs 0, next frame decodes.
